// File: rtl/pan_splitter_if.sv
// Control/audio bundle for pan_splitter.
// The master side drives the sample strobe and buttons; the slave side returns the panned pair.
interface pan_splitter_if;
    logic               ready;
    logic signed [17:0] audio_in;
    logic               pan_up;
    logic               pan_down;
    logic               mute;
    logic signed [17:0] audio_out_l;
    logic signed [17:0] audio_out_r;
    logic               out_valid;
    logic        [4:0]  weight_l;
    logic        [4:0]  weight_r;
    logic               busy;

    modport master (
        output ready, audio_in, pan_up, pan_down, mute,
        input  audio_out_l, audio_out_r, out_valid, weight_l, weight_r, busy
    );

    modport slave (
        input  ready, audio_in, pan_up, pan_down, mute,
        output audio_out_l, audio_out_r, out_valid, weight_l, weight_r, busy
    );
endinterface

// File: rtl/pan_splitter.sv
// Mono-to-stereo panner with button-driven weight ramp and mute fade.
// Two-stage pipeline: pan products on the ready cycle, then gain scaling into the output registers.
module pan_splitter (
    input  logic          clock,
    input  logic          reset,
    pan_splitter_if.slave bus
);
    typedef enum logic [1:0] {PLAY, FADE_OUT, MUTED, FADE_IN} fade_state_e;

    localparam logic [4:0] FULL = 5'd31;
    localparam logic [4:0] MID  = 5'd16;

    fade_state_e        state_q;
    logic        [4:0]  g_q;
    logic        [4:0]  t_q, t_d;
    logic        [4:0]  w_q, w_d;
    logic               up_prev_q, down_prev_q;
    logic               up_edge, down_edge;

    logic               s1_valid_q;
    logic signed [22:0] p_l_q, p_r_q;
    logic        [4:0]  s1_g_q;
    logic signed [22:0] p_l_d, p_r_d;

    logic signed [22:0] scaled_l, scaled_r;
    logic signed [17:0] out_l_q, out_r_q;
    logic               out_valid_q;

    assign up_edge   = bus.pan_up   & ~up_prev_q;
    assign down_edge = bus.pan_down & ~down_prev_q;

    always_comb begin
        t_d = t_q;
        if (up_edge && !down_edge && t_q != FULL)
            t_d = t_q + 5'd1;
        else if (down_edge && !up_edge && t_q != 5'd0)
            t_d = t_q - 5'd1;

        // The weight chases the target seen before this cycle's button edge.
        w_d = w_q;
        if (bus.ready) begin
            if (w_q < t_q)
                w_d = w_q + 5'd1;
            else if (w_q > t_q)
                w_d = w_q - 5'd1;
        end
    end

    // Operands are widened to the full 23-bit product width so the multiply is exact.
    always_comb begin
        p_l_d = $signed({{5{bus.audio_in[17]}}, bus.audio_in}) * $signed({18'd0, w_q});
        p_r_d = $signed({{5{bus.audio_in[17]}}, bus.audio_in}) * $signed({18'd0, FULL - w_q});
    end

    // Taking the upper bits of a signed value is a floor (arithmetic) shift.
    always_comb begin
        scaled_l = $signed({{5{p_l_q[22]}}, p_l_q[22:5]}) * $signed({18'd0, s1_g_q});
        scaled_r = $signed({{5{p_r_q[22]}}, p_r_q[22:5]}) * $signed({18'd0, s1_g_q});
    end

    always_ff @(posedge clock) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            up_prev_q   <= 1'b0;
            down_prev_q <= 1'b0;
            t_q         <= MID;
            w_q         <= MID;
            s1_valid_q  <= 1'b0;
            p_l_q       <= '0;
            p_r_q       <= '0;
            s1_g_q      <= FULL;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            up_prev_q   <= bus.pan_up;
            down_prev_q <= bus.pan_down;
            t_q         <= t_d;
            w_q         <= w_d;
            s1_valid_q  <= bus.ready;
            if (bus.ready) begin
                p_l_q  <= p_l_d;
                p_r_q  <= p_r_d;
                s1_g_q <= g_q;
            end
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_l_q <= scaled_l[22:5];
                out_r_q <= scaled_r[22:5];
            end
        end
    end

    // A reversal mid-fade turns around at the current gain without taking a step.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= PLAY;
            g_q     <= FULL;
        end else begin
            case (state_q)
                PLAY: begin
                    g_q <= FULL;
                    if (bus.mute) state_q <= FADE_OUT;
                end
                FADE_OUT: begin
                    if (!bus.mute) begin
                        state_q <= FADE_IN;
                    end else if (g_q == 5'd0) begin
                        state_q <= MUTED;
                    end else if (bus.ready) begin
                        g_q <= g_q - 5'd1;
                        if (g_q == 5'd1) state_q <= MUTED;
                    end
                end
                MUTED: begin
                    g_q <= 5'd0;
                    if (!bus.mute) state_q <= FADE_IN;
                end
                FADE_IN: begin
                    if (bus.mute) begin
                        state_q <= FADE_OUT;
                    end else if (g_q == FULL) begin
                        state_q <= PLAY;
                    end else if (bus.ready) begin
                        g_q <= g_q + 5'd1;
                        if (g_q == FULL - 5'd1) state_q <= PLAY;
                    end
                end
                default: state_q <= PLAY;
            endcase
        end
    end

    assign bus.audio_out_l = out_l_q;
    assign bus.audio_out_r = out_r_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.weight_l    = w_q;
    assign bus.weight_r    = FULL - w_q;
    assign bus.busy        = (w_q != t_q) || (state_q == FADE_OUT) || (state_q == FADE_IN);
endmodule

// File: tb/tb_pan_splitter.sv
// Randomised and directed bench for pan_splitter against a cycle-level behavioural model.
// The model tracks target, weight, gain and fade direction as plain integers.
module tb_pan_splitter;
    logic clock = 1'b0;
    logic reset;
    pan_splitter_if bus ();

    pan_splitter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int due;
        int l;
        int r;
    } exp_t;

    exp_t q[$];
    int   m_t, m_w, m_g, m_dir, m_cyc;
    bit   m_pu, m_pd, m_on;
    int   exp_l, exp_r;
    int   a, old_t;
    bit   up_e, dn_e, v;

    function automatic int scale(input int p, input int g);
        return ((p >>> 5) * g) >>> 5;
    endfunction

    initial begin
        m_cyc = 0;
        m_on  = 1'b0;
    end

    always @(posedge clock) begin
        m_cyc++;
        if (reset) begin
            m_t = 16; m_w = 16; m_g = 31; m_dir = 0;
            m_pu = 1'b0; m_pd = 1'b0;
            q.delete();
            exp_l = 0; exp_r = 0;
            m_on = 1'b1;
        end else if (m_on) begin
            a = bus.audio_in;
            if (bus.ready)
                q.push_back('{m_cyc + 1, scale(a * m_w, m_g), scale(a * (31 - m_w), m_g)});
            old_t = m_t;
            up_e = bus.pan_up && !m_pu;
            dn_e = bus.pan_down && !m_pd;
            if (up_e && !dn_e && m_t < 31) m_t++;
            else if (dn_e && !up_e && m_t > 0) m_t--;
            if (bus.ready) m_w += (old_t > m_w) - (old_t < m_w);
            // dir: -1 fading out, +1 fading in, 0 resting at full or zero gain
            if (m_dir == 0) begin
                if (m_g == 31 && bus.mute) m_dir = -1;
                else if (m_g == 0 && !bus.mute) m_dir = 1;
            end else if (m_dir < 0) begin
                if (!bus.mute) m_dir = 1;
                else if (m_g == 0) m_dir = 0;
                else if (bus.ready) begin m_g--; if (m_g == 0) m_dir = 0; end
            end else begin
                if (bus.mute) m_dir = -1;
                else if (m_g == 31) m_dir = 0;
                else if (bus.ready) begin m_g++; if (m_g == 31) m_dir = 0; end
            end
            m_pu = bus.pan_up;
            m_pd = bus.pan_down;
        end
    end

    always @(negedge clock) begin
        if (m_on) begin
            v = (q.size() > 0) && (q[0].due == m_cyc);
            if (v) begin
                exp_l = q[0].l;
                exp_r = q[0].r;
                void'(q.pop_front());
            end
            check("out_valid",   bus.out_valid, v);
            check("audio_out_l", bus.audio_out_l, exp_l);
            check("audio_out_r", bus.audio_out_r, exp_r);
            check("weight_l",    bus.weight_l, m_w);
            check("weight_r",    bus.weight_r, 31 - m_w);
            check("busy",        bus.busy, (m_w != m_t) || (m_dir != 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit rdy, input int smp);
        // NOTE: inputs change on the falling edge with blocking assignments, clear of the sampling edge.
        bus.ready    = rdy;
        bus.audio_in = 18'(smp);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(0, 0);
        reset = 1'b0;
    endtask

    task automatic send_and_get(input int smp, output int l, output int r);
        bit found;
        found = 1'b0;
        l = 0; r = 0;
        cyc(1, smp);
        bus.ready = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clock);
            if (bus.out_valid) begin
                l = bus.audio_out_l;
                r = bus.audio_out_r;
                found = 1'b1;
            end
        end
        check("out_valid_timeout", found, 1);
    endtask

    int l, r, guard;

    initial begin
        reset        = 1'b1;
        bus.ready    = 1'b0;
        bus.audio_in = '0;
        bus.pan_up   = 1'b0;
        bus.pan_down = 1'b0;
        bus.mute     = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        check("rst_weight_l", bus.weight_l, 16);
        check("rst_weight_r", bus.weight_r, 15);
        check("rst_busy", bus.busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_l", bus.audio_out_l, 0);

        send_and_get(1000, l, r);
        check("pos_l", l, 484);
        check("pos_r", r, 453);
        send_and_get(-131072, l, r);
        check("neg_l", l, -63488);
        check("neg_r", r, -59520);

        // held button counts once
        bus.pan_up = 1'b1;
        repeat (20) cyc(0, 0);
        bus.pan_up = 1'b0;
        check("hold_target", m_t, 17);
        check("hold_busy", bus.busy, 1);
        cyc(1, 0);
        check("hold_wl", bus.weight_l, 17);
        check("hold_wr", bus.weight_r, 14);
        check("hold_busy_fall", bus.busy, 0);

        // saturation at the left end
        repeat (20) begin
            bus.pan_up = 1'b1; cyc(0, 0);
            bus.pan_up = 1'b0; cyc(0, 0);
        end
        repeat (15) cyc(1, 0);
        check("sat_wl", bus.weight_l, 31);
        check("sat_wr", bus.weight_r, 0);
        check("sat_busy", bus.busy, 0);
        repeat (3) begin
            bus.pan_up = 1'b1; cyc(0, 0);
            bus.pan_up = 1'b0; cyc(0, 0);
        end
        check("sat_hold_wl", bus.weight_l, 31);
        check("sat_hold_busy", bus.busy, 0);

        // full fade-out
        do_reset();
        bus.mute = 1'b1;
        repeat (40) cyc(1, 1000);
        check("mute_gain", m_g, 0);
        check("mute_busy", bus.busy, 0);
        repeat (3) cyc(0, 0);
        check("mute_out_l", bus.audio_out_l, 0);
        check("mute_out_r", bus.audio_out_r, 0);

        // reverse at g=10
        do_reset();
        bus.mute = 1'b1;
        guard = 0;
        while (m_g != 10 && guard < 100) begin cyc(1, 1000); guard++; end
        check("reach_g10", m_g, 10);
        bus.mute = 1'b0;
        cyc(1, 1000);
        check("turn_g", m_g, 10);
        cyc(1, 1000);
        check("rise_g11", m_g, 11);
        cyc(1, 1000);
        check("rise_g12", m_g, 12);
        repeat (25) cyc(1, 1000);
        check("rise_full", m_g, 31);
        check("rise_busy", bus.busy, 0);
        send_and_get(1000, l, r);
        check("rise_out_l", l, 484);

        // simultaneous edges, then a lone pan_down
        bus.pan_up = 1'b1; bus.pan_down = 1'b1;
        cyc(0, 0);
        bus.pan_up = 1'b0; bus.pan_down = 1'b0;
        check("simul_target", m_t, 16);
        repeat (3) cyc(1, 0);
        check("simul_wl", bus.weight_l, 16);
        bus.pan_down = 1'b1; cyc(0, 0);
        bus.pan_down = 1'b0;
        repeat (2) cyc(1, 0);
        check("down_wl", bus.weight_l, 15);

        // reset mid-fade with a sample in flight
        do_reset();
        bus.mute = 1'b1;
        guard = 0;
        while (m_g != 5 && guard < 100) begin cyc(1, 500); guard++; end
        reset = 1'b1; bus.pan_up = 1'b1;
        cyc(1, 500);
        reset = 1'b0; bus.pan_up = 1'b0; bus.mute = 1'b0;
        check("flush_valid0", bus.out_valid, 0);
        repeat (3) begin
            cyc(0, 0);
            check("flush_valid", bus.out_valid, 0);
        end
        check("flush_gain", m_g, 31);
        check("flush_busy", bus.busy, 0);
        send_and_get(1000, l, r);
        check("flush_out_r", r, 453);

        // randomised traffic
        repeat (3000) begin
            if ($urandom_range(0, 9) == 0) bus.pan_up   = ~bus.pan_up;
            if ($urandom_range(0, 9) == 0) bus.pan_down = ~bus.pan_down;
            if ($urandom_range(0, 49) == 0) bus.mute    = ~bus.mute;
            reset = ($urandom_range(0, 199) == 0);
            cyc(1'($urandom_range(0, 1)), int'($urandom));
        end
        reset = 1'b0;
        repeat (4) cyc(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
